// File: rtl/gear_pkg.sv
// Shared definitions for the gear selector: drive modes, selector/led bit positions,
// and helpers that map the selector vector onto modes and legal transitions.
package gear_pkg;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        REV   = 2'd1,
        NEUT  = 2'd2,
        DRIVE = 2'd3
    } mode_t;

    // Selector switch bit positions within sw[3:0] = {P,R,N,D}
    localparam int SW_P = 3;
    localparam int SW_R = 2;
    localparam int SW_N = 1;
    localparam int SW_D = 0;
    localparam logic [3:0] SW_RST = 4'b1000;

    // led indicator positions, offset from NUM_FWD (thermometer occupies the low bits)
    localparam int LED_P_OFS = 0;
    localparam int LED_N_OFS = 1;
    localparam int LED_R_OFS = 2;

    function automatic mode_t sw_to_mode(input logic [3:0] v);
        mode_t m;
        m = PARK;
        if (v[SW_R])      m = REV;
        else if (v[SW_N]) m = NEUT;
        else if (v[SW_D]) m = DRIVE;
        return m;
    endfunction

    // Only REV<->DRIVE is forbidden; everything through PARK/NEUT is legal.
    function automatic logic move_allowed(input mode_t cur, input mode_t req);
        return (cur == PARK) || (cur == NEUT) || (req == PARK) || (req == NEUT);
    endfunction

endpackage

// File: rtl/gear_shift_ctrl_if.sv
// Selector/throttle inputs and led/gear/fault indications of the gear controller.
// master drives the switches and throttle, slave is the controller itself.
interface gear_shift_ctrl_if #(
    parameter int NUM_FWD = 4
);
    logic [3:0]         sw;
    logic               throttle;
    logic [NUM_FWD+2:0] led;
    logic [3:0]         gear;
    logic               fault;

    modport master (output sw, output throttle, input led, input gear, input fault);
    modport slave  (input sw, input throttle, output led, output gear, output fault);
endinterface

// File: rtl/sw_debounce.sv
// One selector bit: 2-flop synchroniser then accept after DEB_CYCLES equal samples.
// Latency 2 + DEB_CYCLES cycles from a stable change; no backpressure.
module sw_debounce #(
    parameter int   DEB_CYCLES = 16,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= RST_VAL;
            sync2  <= RST_VAL;
            cnt    <= '0;
            stable <= RST_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // cnt holds how many consecutive samples already disagreed with stable
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gear_shift_ctrl.sv
// PRNDL selector with interlocks and throttle-timed automatic shifting in DRIVE.
// Latency DEB_CYCLES+3 from stable sw to led; no backpressure, fault is a 1-cycle pulse.
module gear_shift_ctrl
    import gear_pkg::*;
#(
    parameter int NUM_FWD      = 4,
    parameter int DEB_CYCLES   = 16,
    parameter int SHIFT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    gear_shift_ctrl_if.slave  bus
);
    localparam int LEDW = NUM_FWD + 3;
    localparam int SCW  = $clog2(SHIFT_CYCLES);

    logic [3:0]      db;
    logic [3:0]      db_prev;
    logic            thr_prev;
    mode_t           mode;
    mode_t           mode_nxt;
    mode_t           req_mode;
    logic [3:0]      gear_q;
    logic [3:0]      gear_nxt;
    logic [SCW-1:0]  cnt;
    logic [SCW-1:0]  cnt_nxt;
    logic [LEDW-1:0] led_q;
    logic [LEDW-1:0] led_nxt;
    logic            fault_q;
    logic            fault_nxt;
    logic            changed;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_VAL    (SW_RST[i])
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (bus.sw[i]),
            .stable (db[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= PARK;
            gear_q   <= '0;
            cnt      <= '0;
            fault_q  <= 1'b0;
            led_q    <= LEDW'(1) << (NUM_FWD + LED_P_OFS);
            db_prev  <= SW_RST;
            thr_prev <= 1'b0;
        end else begin
            mode     <= mode_nxt;
            gear_q   <= gear_nxt;
            cnt      <= cnt_nxt;
            fault_q  <= fault_nxt;
            led_q    <= led_nxt;
            db_prev  <= db;
            thr_prev <= bus.throttle;
        end
    end

    always_comb begin
        mode_nxt  = mode;
        gear_nxt  = gear_q;
        cnt_nxt   = cnt;
        fault_nxt = 1'b0;
        led_nxt   = '0;
        req_mode  = sw_to_mode(db);
        // Rejections only pulse once: they are tied to the debounced vector changing
        changed   = (db != db_prev);

        if (!$onehot(db)) begin
            fault_nxt = changed;
        end else if (req_mode != mode) begin
            if (move_allowed(mode, req_mode)) mode_nxt = req_mode;
            else                              fault_nxt = changed;
        end

        if (mode_nxt != mode) begin
            cnt_nxt  = '0;
            gear_nxt = (mode_nxt == DRIVE) ? 4'd1 : 4'd0;
        end else if (mode == DRIVE) begin
            if (bus.throttle != thr_prev) begin
                cnt_nxt = '0;
            end else if (cnt == SCW'(SHIFT_CYCLES - 1)) begin
                cnt_nxt = '0;
                if (bus.throttle) begin
                    if (gear_q < 4'(NUM_FWD)) gear_nxt = gear_q + 4'd1;
                end else begin
                    if (gear_q > 4'd1) gear_nxt = gear_q - 4'd1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            cnt_nxt  = '0;
            gear_nxt = '0;
        end

        case (mode_nxt)
            DRIVE: begin
                for (int k = 0; k < NUM_FWD; k++) led_nxt[k] = (4'(k) < gear_nxt);
            end
            REV:     led_nxt[NUM_FWD + LED_R_OFS] = 1'b1;
            NEUT:    led_nxt[NUM_FWD + LED_N_OFS] = 1'b1;
            default: led_nxt[NUM_FWD + LED_P_OFS] = 1'b1;
        endcase
    end

    assign bus.led   = led_q;
    assign bus.gear  = gear_q;
    assign bus.fault = fault_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed scenarios then randomized selector/throttle traffic, checked cycle by cycle
// against a window-based reference model of the selector and shift rules.
module tb_gear_shift_ctrl;
    localparam int NF    = 4;
    localparam int DEB   = 4;
    localparam int SHIFT = 8;

    localparam logic [3:0] SP = 4'b1000;
    localparam logic [3:0] SR = 4'b0100;
    localparam logic [3:0] SN = 4'b0010;
    localparam logic [3:0] SD = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gear_shift_ctrl_if #(.NUM_FWD(NF)) bus();

    gear_shift_ctrl #(
        .NUM_FWD      (NF),
        .DEB_CYCLES   (DEB),
        .SHIFT_CYCLES (SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad = 0;
    int fault_cnt = 0;

    // ---------------- reference model ----------------
    logic [3:0] m_hist [0:DEB+1];
    logic [3:0] m_db, m_db_prev, m_mode, m_nd;
    logic [6:0] m_led;
    logic       m_fault, m_thr_prev, m_moved;
    int         m_gear, m_run, m_ones;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DEB + 1; k++) m_hist[k] = SP;
            m_db = SP; m_db_prev = SP; m_mode = SP;
            m_gear = 0; m_run = 0; m_fault = 1'b0; m_thr_prev = 1'b0;
        end else begin
            m_fault = 1'b0;
            m_moved = 1'b0;
            if ($countones(m_db) != 1) begin
                m_fault = (m_db != m_db_prev);
            end else if (m_db != m_mode) begin
                if ((m_mode == SR || m_mode == SD) && (m_db == SR || m_db == SD)) begin
                    m_fault = (m_db != m_db_prev);
                end else begin
                    m_mode  = m_db;
                    m_gear  = (m_db == SD) ? 1 : 0;
                    m_run   = 0;
                    m_moved = 1'b1;
                end
            end
            if (!m_moved && m_mode == SD) begin
                if (bus.throttle != m_thr_prev) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == SHIFT) begin
                        m_run = 0;
                        if (bus.throttle) m_gear = (m_gear < NF) ? m_gear + 1 : NF;
                        else              m_gear = (m_gear > 1) ? m_gear - 1 : 1;
                    end
                end
            end
            m_thr_prev = bus.throttle;
            m_db_prev  = m_db;
            for (int k = DEB + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = bus.sw;
            // A bit is accepted once the last DEB synchronised samples all agree
            for (int b = 0; b < 4; b++) begin
                m_ones = 0;
                for (int k = 2; k <= DEB + 1; k++) m_ones += int'(m_hist[k][b]);
                if (m_ones == DEB)    m_nd[b] = 1'b1;
                else if (m_ones == 0) m_nd[b] = 1'b0;
                else                  m_nd[b] = m_db[b];
            end
            m_db = m_nd;
        end
        if (m_mode == SD)      m_led = 7'((1 << m_gear) - 1);
        else if (m_mode == SR) m_led = 7'b1000000;
        else if (m_mode == SN) m_led = 7'b0100000;
        else                   m_led = 7'b0010000;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat);
        total++;
        assert (lat >= DEB + 2 && lat <= DEB + 4) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d+/-1", tag, lat, DEB + 3);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.fault === 1'b1) fault_cnt++;
            check("model_led", 32'(bus.led), 32'(m_led));
            check("model_gear", 32'(bus.gear), 32'(m_gear));
            check("model_fault", 32'(bus.fault), 32'(m_fault));
        end
    endtask

    task automatic wait_led(input logic [6:0] want, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (bus.led === want) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_gear(input logic lvl, input int n, output int nchg, output int d1, output int d2);
        int times[$];
        logic [3:0] prev;
        bus.throttle = lvl;
        for (int i = 0; i < n; i++) begin
            prev = bus.gear;
            tick(1);
            if (bus.gear !== prev) times.push_back(i);
        end
        nchg = times.size();
        d1 = (nchg >= 2) ? times[1] - times[0] : -1;
        d2 = (nchg >= 3) ? times[2] - times[1] : -1;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] pick [0:8];
    int lat, nchg, d1, d2, hold;

    initial begin
        pick[0] = SP; pick[1] = SR; pick[2] = SN; pick[3] = SD; pick[4] = SD;
        pick[5] = SN; pick[6] = 4'b0000; pick[7] = 4'b0011; pick[8] = 4'b1001;

        bus.sw = SP;
        bus.throttle = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        fault_cnt = 0;
        tick(20);
        check("reset_led", 32'(bus.led), 32'(7'b0010000));
        check("reset_gear", 32'(bus.gear), 0);
        check("reset_no_fault", fault_cnt, 0);

        bus.sw = SN;
        wait_led(7'b0100000, lat);
        check_lat("lat_neutral", lat);
        tick(12);
        bus.sw = SD;
        wait_led(7'b0000001, lat);
        check_lat("lat_drive", lat);
        check("drive_gear", 32'(bus.gear), 1);
        tick(10);

        run_gear(1'b1, 40, nchg, d1, d2);
        check("up_changes", nchg, 3);
        check("up_int1", d1, SHIFT);
        check("up_int2", d2, SHIFT);
        check("up_gear", 32'(bus.gear), NF);
        check("up_led", 32'(bus.led), 32'(7'b0001111));
        run_gear(1'b0, 40, nchg, d1, d2);
        check("down_changes", nchg, 3);
        check("down_int1", d1, SHIFT);
        check("down_gear", 32'(bus.gear), 1);

        fault_cnt = 0;
        bus.sw = SR;
        tick(20);
        check("d2r_fault", fault_cnt, 1);
        check("d2r_led", 32'(bus.led), 32'(7'b0000001));
        fault_cnt = 0;
        bus.sw = 4'b0011;
        tick(20);
        check("multihot_fault", fault_cnt, 1);
        check("multihot_gear", 32'(bus.gear), 1);
        bus.sw = SD;
        tick(20);

        fault_cnt = 0;
        bus.sw = SN;
        tick(3);
        bus.sw = SD;
        tick(20);
        check("glitch_fault", fault_cnt, 0);
        check("glitch_led", 32'(bus.led), 32'(7'b0000001));

        bus.throttle = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.gear === 4'd3) break;
            tick(1);
        end
        check("pre_rst_gear", 32'(bus.gear), 3);
        tick(3);
        rst = 1'b1;
        bus.sw = SP;
        bus.throttle = 1'b0;
        tick(1);
        check("rst_led", 32'(bus.led), 32'(7'b0010000));
        check("rst_gear", 32'(bus.gear), 0);
        bus.throttle = 1'b1;
        tick(1);
        bus.throttle = 1'b0;
        tick(1);
        rst = 1'b0;
        fault_cnt = 0;
        tick(12);
        check("post_rst_led", 32'(bus.led), 32'(7'b0010000));
        check("post_rst_fault", fault_cnt, 0);

        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                bus.sw = pick[$urandom_range(0, 8)];
                hold = $urandom_range(1, 25);
            end
            hold--;
            if ($urandom_range(0, 14) == 0) bus.throttle = ~bus.throttle;
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gear_shift_ctrl.md
GEAR_SHIFT_CTRL -- requirements
Module: gear_shift_ctrl

Interface
REQ-001 Parameter NUM_FWD, default 4: number of forward gears, legal range 2..8.
REQ-002 Parameter DEB_CYCLES, default 16: cycles a synchronised selector bit must be stable before it is accepted, minimum 2.
REQ-003 Parameter SHIFT_CYCLES, default 1024: consecutive throttle-high or throttle-low cycles that trigger one gear step, minimum 2.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sw  in  4  selector switches {P,R,N,D}, bit 3 = P, bit 0 = D; asynchronous to clk.
REQ-007 throttle  in  1  accelerate request; synchronous to clk.
REQ-008 led  out  NUM_FWD+3  {R,N,P,Dn..D1}: led[NUM_FWD+2]=R, led[NUM_FWD+1]=N, led[NUM_FWD]=P, led[NUM_FWD-1:0]=drive-gear thermometer.
REQ-009 gear  out  4  current forward gear, 0 when not in D, 1..NUM_FWD in D.
REQ-010 fault  out  1  one-cycle pulse on each rejected selector request.

Function
REQ-011 Each sw bit shall pass a 2-flop synchroniser, then a debouncer that updates its accepted value only after DEB_CYCLES consecutive equal synchronised samples.
REQ-012 A selector request exists when the debounced vector is one-hot and differs from the current mode.
REQ-013 Mode FSM states: PARK, REV, NEUT, DRIVE.
REQ-014 Permitted transitions: PARK->any; NEUT->any; REV->PARK/NEUT; DRIVE->PARK/NEUT.
REQ-015 REV->DRIVE and DRIVE->REV are forbidden: mode holds, fault pulses once per new debounced vector value.
REQ-016 Debounced vector all-zero or multi-hot: mode holds, fault pulses once per new debounced vector value; no further pulses while the value is unchanged.
REQ-017 Mode, gear, led and fault are registered; a change in debounced sw is reflected on the next clk edge.
REQ-018 End-to-end latency from a stable sw change to led update is DEB_CYCLES+3 cycles, +/-1.
REQ-019 On entry to DRIVE, gear = 1 and the shift counter clears.
REQ-020 In DRIVE, the shift counter counts consecutive cycles with an unchanged throttle level and clears on every throttle edge.
REQ-021 Upshift: counter reaches SHIFT_CYCLES with throttle high -> gear+1 (saturating at NUM_FWD), counter clears.
REQ-022 Downshift: counter reaches SHIFT_CYCLES with throttle low -> gear-1 (saturating at 1), counter clears.
REQ-023 At saturation the counter still clears on terminal count; gear stays unchanged.
REQ-024 Leaving DRIVE forces gear = 0 in the same cycle the mode changes; the counter clears.
REQ-025 led decode: exactly one of {R,N,P} high outside DRIVE with the thermometer all zero; in DRIVE, R/N/P are low and led[k]=1 for k<gear.
REQ-026 A mode change and a shift terminal count in the same cycle: the mode change wins and no shift occurs.

Reset
REQ-027 rst high at a clk edge sets mode=PARK, gear=0, counter=0, fault=0, led = P bit only.
REQ-028 rst sets synchroniser and debouncer state to "P accepted" (4'b1000) so no fault follows reset release.
REQ-029 rst asserted mid-shift or mid-debounce discards the pending action.

Structure
REQ-030 A shared package gear_pkg holds the mode enum (PARK, REV, NEUT, DRIVE) and the led bit-index constants.
REQ-031 One sub-module, sw_debounce (parametrised by DEB_CYCLES, one bit wide), is instantiated four times.
REQ-032 Counter widths derive from $clog2 of the parameters; no hard-coded widths.

Verification (NUM_FWD=4, DEB_CYCLES=4, SHIFT_CYCLES=8)
REQ-033 Reset then sw=1000 held -> led=0010000, gear=0, fault never high.
REQ-034 sw 1000->0010 (N)->0001 (D) each held 20 cycles -> led 0100000 then 0000001, gear=1, each update 7+/-1 cycles after the sw change.
REQ-035 In D, throttle high 40 cycles -> gear steps 1->2->3->4 at 8-cycle intervals and holds at 4 (led 0001111); throttle low 40 cycles -> gear 4->1.
REQ-036 In D, sw->0100 (R) -> one fault pulse, mode stays DRIVE; sw->0011 -> one fault pulse, mode stays DRIVE.
REQ-037 sw glitch of 3-cycle width -> no mode change, no fault.
REQ-038 rst asserted at gear=3 mid-count -> next cycle led=0010000, gear=0; throttle activity during rst has no effect.
